// File: rtl/record_note_if.sv
// Song-memory write port driven by the note recorder.
interface record_note_if #(
  parameter int ADDR_W = 6,
  parameter int NOTE_W = 4,
  parameter int DUR_W  = 8
);
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [NOTE_W+DUR_W-1:0]   mem_data;

  modport master (output mem_we, output mem_addr, output mem_data);
  modport slave  (input  mem_we, input  mem_addr, input  mem_data);
endinterface

// File: rtl/record_note.sv
// Note recorder: turns a live key-code stream into run-length {note, dur}
// entries written into song memory, one write per held note or rest.
module record_note #(
  parameter int ADDR_W   = 6,
  parameter int NOTE_W   = 4,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              record,
  input  logic              stop,
  input  logic [NOTE_W-1:0] note_in,
  record_note_if.master     mem,
  output logic [ADDR_W-1:0] limit,
  output logic              has_data,
  output logic              recording,
  output logic              full,
  output logic              done
);
  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0]  DUR_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {IDLE, REC, DONE} state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
  logic [NOTE_W-1:0] cur_note, cur_n;
  logic [DUR_W-1:0]  dur, dur_n;
  logic [PS_W-1:0]   prescale, pre_n;
  logic [ADDR_W-1:0] limit_n, addr_q, addr_n;
  logic              hd_n, full_n, we_q, we_n, wr;
  entry_t            data_q, data_n, ent;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      cur_note <= '0;
      dur      <= '0;
      prescale <= '0;
      limit    <= '0;
      has_data <= 1'b0;
      full     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state    <= state_n;
      wr_ptr   <= wr_ptr_n;
      cur_note <= cur_n;
      dur      <= dur_n;
      prescale <= pre_n;
      limit    <= limit_n;
      has_data <= hd_n;
      full     <= full_n;
      we_q     <= we_n;
      addr_q   <= addr_n;
      data_q   <= data_n;
    end
  end

  always_comb begin
    state_n  = state;
    wr_ptr_n = wr_ptr;
    cur_n    = cur_note;
    dur_n    = dur;
    pre_n    = prescale;
    limit_n  = limit;
    hd_n     = has_data;
    full_n   = full;
    we_n     = 1'b0;
    addr_n   = addr_q;
    data_n   = data_q;
    wr       = 1'b0;
    ent      = '{note: cur_note, dur: dur};
    case (state)
      IDLE: if (record) begin
        state_n  = REC;
        wr_ptr_n = '0;
        cur_n    = note_in;
        dur_n    = '0;
        pre_n    = '0;
        limit_n  = '0;
        hd_n     = 1'b0;
        full_n   = 1'b0;
      end
      REC: begin
        if (stop) begin
          wr      = (dur != '0);
          state_n = DONE;
        end else if (note_in != cur_note) begin
          // zero-length runs are key bounce, not notes
          wr    = (dur != '0);
          cur_n = note_in;
          dur_n = '0;
          pre_n = '0;
        end else if (prescale == PS_LAST) begin
          pre_n = '0;
          if (dur != DUR_MAX) begin
            dur_n = dur + DUR_W'(1);
          end else begin
            // split long notes; the current tick starts the next entry
            wr    = 1'b1;
            dur_n = DUR_W'(1);
          end
        end else begin
          pre_n = prescale + PS_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (wr) begin
      we_n    = 1'b1;
      addr_n  = wr_ptr;
      data_n  = ent;
      limit_n = wr_ptr;
      hd_n    = 1'b1;
      if (wr_ptr == ADDR_MAX) begin
        full_n  = 1'b1;
        state_n = DONE;
      end else begin
        wr_ptr_n = wr_ptr + ADDR_W'(1);
      end
    end
  end

  assign mem.mem_we   = we_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_data = data_q;
  assign recording    = (state == REC);
  assign done         = (state == DONE);
endmodule

// File: tb/tb_record_note.sv
// Directed bench for record_note: per-row vector table plus hand-written
// sequences for saturation, full memory and asynchronous reset.
module tb_record_note;
  localparam int ADDR_W = 3, NOTE_W = 4, DUR_W = 4, TICK_DIV = 4;

  logic clock = 1'b0, reset = 1'b1, record = 1'b0, stop = 1'b0;
  logic [NOTE_W-1:0] note_in = '0;
  logic [ADDR_W-1:0] limit;
  logic has_data, recording, full, done;

  record_note_if #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus ();

  record_note #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)) dut (
    .clock(clock), .reset(reset), .record(record), .stop(stop), .note_in(note_in),
    .mem(bus.master), .limit(limit), .has_data(has_data), .recording(recording),
    .full(full), .done(done)
  );

  always #5 clock = ~clock;

  int errors = 0, checks = 0;
  int wlog_addr[$];
  int wlog_data[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (bus.mem_we) begin
      wlog_addr.push_back(int'(bus.mem_addr));
      wlog_data.push_back(int'(bus.mem_data));
    end
  endtask

  typedef struct {
    logic       rec, stp;
    logic [3:0] note;
    int         n;
    logic       we;
    logic [2:0] addr;
    logic [7:0] data;
    logic       rcd, dn;
    logic [2:0] lim;
    logic       hd, fl;
  } vec_t;

  vec_t vt[20];

  initial begin
    //        rec  stp  note n   we   addr  data   rcd  dn   lim  hd   fl
    // basic capture
    vt[0]  = '{1'b1,1'b0,4'd5, 1, 1'b0,3'd0,8'h00, 1'b1,1'b0,3'd0,1'b0,1'b0};
    vt[1]  = '{1'b0,1'b0,4'd5,10, 1'b0,3'd0,8'h00, 1'b1,1'b0,3'd0,1'b0,1'b0};
    vt[2]  = '{1'b0,1'b0,4'd0, 1, 1'b1,3'd0,8'h52, 1'b1,1'b0,3'd0,1'b1,1'b0};
    vt[3]  = '{1'b0,1'b0,4'd0, 8, 1'b0,3'd0,8'h00, 1'b1,1'b0,3'd0,1'b1,1'b0};
    vt[4]  = '{1'b0,1'b1,4'd0, 1, 1'b1,3'd1,8'h02, 1'b0,1'b1,3'd1,1'b1,1'b0};
    vt[5]  = '{1'b0,1'b0,4'd0, 1, 1'b0,3'd0,8'h00, 1'b0,1'b0,3'd1,1'b1,1'b0};
    // glitch discard
    vt[6]  = '{1'b1,1'b0,4'd3, 1, 1'b0,3'd0,8'h00, 1'b1,1'b0,3'd0,1'b0,1'b0};
    vt[7]  = '{1'b0,1'b0,4'd7, 1, 1'b0,3'd0,8'h00, 1'b1,1'b0,3'd0,1'b0,1'b0};
    vt[8]  = '{1'b0,1'b0,4'd3, 1, 1'b0,3'd0,8'h00, 1'b1,1'b0,3'd0,1'b0,1'b0};
    vt[9]  = '{1'b0,1'b0,4'd3,12, 1'b0,3'd0,8'h00, 1'b1,1'b0,3'd0,1'b0,1'b0};
    vt[10] = '{1'b0,1'b1,4'd3, 1, 1'b1,3'd0,8'h33, 1'b0,1'b1,3'd0,1'b1,1'b0};
    vt[11] = '{1'b0,1'b0,4'd3, 1, 1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,1'b1,1'b0};
    // empty session, then stop in IDLE is ignored
    vt[12] = '{1'b1,1'b0,4'd2, 1, 1'b0,3'd0,8'h00, 1'b1,1'b0,3'd0,1'b0,1'b0};
    vt[13] = '{1'b0,1'b1,4'd2, 1, 1'b0,3'd0,8'h00, 1'b0,1'b1,3'd0,1'b0,1'b0};
    vt[14] = '{1'b0,1'b1,4'd2, 1, 1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,1'b0,1'b0};
    // stop beats a simultaneous note change; record in DONE ignored
    vt[15] = '{1'b1,1'b0,4'd4, 1, 1'b0,3'd0,8'h00, 1'b1,1'b0,3'd0,1'b0,1'b0};
    vt[16] = '{1'b0,1'b0,4'd4, 8, 1'b0,3'd0,8'h00, 1'b1,1'b0,3'd0,1'b0,1'b0};
    vt[17] = '{1'b0,1'b1,4'd6, 1, 1'b1,3'd0,8'h42, 1'b0,1'b1,3'd0,1'b1,1'b0};
    vt[18] = '{1'b1,1'b0,4'd6, 1, 1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,1'b1,1'b0};
    vt[19] = '{1'b0,1'b0,4'd6, 1, 1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,1'b1,1'b0};

    #12;
    chk("reset mem_we", int'(bus.mem_we), 0);
    chk("reset recording", int'(recording), 0);
    chk("reset done", int'(done), 0);
    chk("reset limit", int'(limit), 0);
    chk("reset has_data", int'(has_data), 0);
    chk("reset full", int'(full), 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      int mid_we;
      mid_we = 0;
      record  = vt[i].rec;
      stop    = vt[i].stp;
      note_in = vt[i].note;
      for (int k = 0; k < vt[i].n; k++) begin
        step();
        record = 1'b0;
        stop   = 1'b0;
        if (k < vt[i].n - 1 && bus.mem_we) mid_we++;
      end
      chk($sformatf("row%0d mid writes", i), mid_we, 0);
      chk($sformatf("row%0d mem_we", i), int'(bus.mem_we), int'(vt[i].we));
      if (vt[i].we) begin
        chk($sformatf("row%0d mem_addr", i), int'(bus.mem_addr), int'(vt[i].addr));
        chk($sformatf("row%0d mem_data", i), int'(bus.mem_data), int'(vt[i].data));
      end
      chk($sformatf("row%0d recording", i), int'(recording), int'(vt[i].rcd));
      chk($sformatf("row%0d done", i), int'(done), int'(vt[i].dn));
      chk($sformatf("row%0d limit", i), int'(limit), int'(vt[i].lim));
      chk($sformatf("row%0d has_data", i), int'(has_data), int'(vt[i].hd));
      chk($sformatf("row%0d full", i), int'(full), int'(vt[i].fl));
    end

    // saturation split: 17 ticks of note 9 -> {9,15} then {9,2}
    wlog_addr.delete(); wlog_data.delete();
    record = 1'b1; note_in = 4'd9; step(); record = 1'b0;
    repeat (68) step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("sat writes", wlog_addr.size(), 2);
    if (wlog_addr.size() == 2) begin
      chk("sat addr0", wlog_addr[0], 0);
      chk("sat data0", wlog_data[0], 'h9F);
      chk("sat addr1", wlog_addr[1], 1);
      chk("sat data1", wlog_data[1], 'h92);
    end
    chk("sat limit", int'(limit), 1);
    chk("sat done", int'(done), 1);
    step();

    // full: nine alternating 2-tick notes, only eight land
    wlog_addr.delete(); wlog_data.delete();
    begin
      logic [3:0] cur;
      cur = 4'd1;
      record = 1'b1; note_in = cur; step(); record = 1'b0;
      for (int k = 0; k < 8; k++) begin
        repeat (8) step();
        cur = (cur == 4'd1) ? 4'd2 : 4'd1;
        note_in = cur;
        step();
        if (k == 6) chk("full early", int'(full), 0);
        if (k == 7) begin
          chk("full mem_we", int'(bus.mem_we), 1);
          chk("full flag", int'(full), 1);
          chk("full done", int'(done), 1);
          chk("full limit", int'(limit), 7);
          chk("full recording", int'(recording), 0);
        end
      end
      repeat (8) step();
      stop = 1'b1; step(); stop = 1'b0;
      chk("full writes", wlog_addr.size(), 8);
      for (int i = 0; i < 8 && i < wlog_addr.size(); i++) begin
        chk($sformatf("full addr%0d", i), wlog_addr[i], i);
        chk($sformatf("full data%0d", i), wlog_data[i], (i % 2 == 0) ? 'h12 : 'h22);
      end
      chk("full hold", int'(full), 1);
      chk("full limit hold", int'(limit), 7);
    end

    // asynchronous reset while a write is on the bus
    record = 1'b1; note_in = 4'd5; step(); record = 1'b0;
    repeat (4) step();
    note_in = 4'd6; step();
    chk("rst pre mem_we", int'(bus.mem_we), 1);
    chk("rst pre data", int'(bus.mem_data), 'h51);
    #1 reset = 1'b1;
    #1;
    chk("rst mem_we", int'(bus.mem_we), 0);
    chk("rst recording", int'(recording), 0);
    chk("rst limit", int'(limit), 0);
    chk("rst has_data", int'(has_data), 0);
    #1 reset = 1'b0;
    wlog_addr.delete(); wlog_data.delete();
    stop = 1'b1; step(); stop = 1'b0;
    step();
    chk("post rst writes", wlog_addr.size(), 0);
    chk("post rst recording", int'(recording), 0);
    chk("post rst done", int'(done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/record_note.md
# record_note

Note recorder that captures a live key code stream into the song memory as run-length entries of note plus duration. It is the write side of the song memory; the playback address sequencer consumes `limit` as its last-address bound. One `record` pulse starts a session. The block emits one memory write per held note or rest, and stops on `stop` or when memory is full.

## Interface
- `ADDR_W`, 6: song memory address width; capacity 2^ADDR_W entries.
- `NOTE_W`, 4: key code width; code 0 = rest (no key).
- `DUR_W`, 8: duration field width, in ticks.
- `TICK_DIV`, 50000: clock cycles per duration tick (≥2).

- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `record`  in  1  one-cycle start pulse; honoured only in IDLE.
- `stop`  in  1  one-cycle end pulse; honoured only in REC.
- `note_in`  in  NOTE_W  current key code, already synchronised and debounced upstream.
- `mem_we`  out  1  registered one-cycle write strobe.
- `mem_addr`  out  ADDR_W  write address, valid while `mem_we`=1.
- `mem_data`  out  NOTE_W+DUR_W  {note, dur}; note occupies the MSBs.
- `limit`  out  ADDR_W  address of the last entry written in the session.
- `has_data`  out  1  at least one entry was written in the session.
- `recording`  out  1  high while in REC.
- `full`  out  1  session ended because memory filled.
- `done`  out  1  one-cycle pulse when a session ends.

## Operation
- Reset value of all outputs and internal registers is 0. State is IDLE.
- States: IDLE, REC, DONE.
- IDLE:
  - `record`=1 → REC.
  - On the same edge: `wr_ptr`←0, `cur_note`←`note_in`, `dur`←0, `prescale`←0, `limit`←0, `has_data`←0, `full`←0.
  - `stop` is ignored.
- REC: `recording`=1. Per edge, highest priority first:
  1. **`stop`=1**: flush, i.e. write {`cur_note`,`dur`} if `dur`>0, then go to DONE. A simultaneous note change is ignored.
  2. **`note_in`≠`cur_note`**: write the entry if `dur`>0; otherwise discard it as a glitch. Then `cur_note`←`note_in`, `dur`←0, `prescale`←0. A tick falling on the same edge is discarded.
  3. **Tick** (`prescale`=TICK_DIV−1): `prescale`←0.
     - If `dur`<2^DUR_W−1: `dur`←`dur`+1.
     - Else: write {`cur_note`, 2^DUR_W−1}, then `dur`←1. Long notes are split and total ticks are conserved.
  4. **Otherwise**: `prescale`←`prescale`+1.
- Write action, registered:
  - `mem_we`←1, `mem_addr`←`wr_ptr`, `mem_data`←entry.
  - `limit`←`wr_ptr`, `has_data`←1, `wr_ptr`←`wr_ptr`+1.
- Full: a write with `wr_ptr`=2^ADDR_W−1 sets `full`←1 and moves to DONE on the same edge. No further writes occur. `wr_ptr` never wraps.
- DONE: lasts one cycle with `done`=1, then returns to IDLE. `record` is ignored in DONE.
- `limit`, `has_data` and `full` hold their values until the next accepted `record`.
- `record` in REC is ignored.
- Rests (code 0) are recorded as ordinary entries.
- Arithmetic is unsigned. `dur` saturates as described and never wraps.

## Timing
- `mem_we` is high exactly one cycle: the cycle after the edge that decided the write. `mem_addr` and `mem_data` are valid in that same cycle.
- There are at most one write per cycle. Back-to-back writes are legal, e.g. two note changes on consecutive edges.
- `limit` and `has_data` update on the same edge that raises `mem_we`.
- `done` rises on the edge that enters DONE, concurrent with the final flush `mem_we` if there is one.
- `recording` falls on that same edge.
- Earliest restart: `record` in the first IDLE cycle after DONE, i.e. 2 cycles after `stop`.
- Reset mid-session, asynchronous:
  - All outputs drop immediately, including any `mem_we` in flight.
  - The partial entry is lost.
  - Memory contents already written are untouched.

## Test plan
Bench parameters: TICK_DIV=4, DUR_W=4, ADDR_W=3.

- **Basic capture:** `record` with `note_in`=5; hold 10 cycles; change to 0; hold 8 cycles; `stop` → writes addr0={5,2} and addr1={0,2}; `limit`=1, `has_data`=1, one `done` pulse, `full`=0.
- **Glitch discard:** `note_in` 3→7→3 within 2 cycles after `record` → no write for 3 or for 7. Holding 3 then `stop` after 12 cycles yields a single entry {3,3}.
- **Saturation split:** hold `note_in`=9 for 17 ticks (68 cycles), then `stop` → addr0={9,15}, addr1={9,2}; `limit`=1.
- **Full:** 9 alternating notes of 2 ticks each → exactly 8 writes at addr 0..7; `full`=1 and `done` on the 8th write; the 9th note is not written; `limit`=7.
- **Empty session and priority:** `record`, then `stop` on the 2nd cycle → no `mem_we`, `has_data`=0, `limit`=0, `done` pulse. In a separate session, `stop` together with a note change → a single flush of the old note.
- **Reset mid-session:** assert `reset` while `mem_we`=1 → `mem_we`, `recording`, `limit` and `has_data` go to 0 immediately. After release: state IDLE, and `stop` has no effect.
